s1423_cmp_count_unit: RTL

//  Parametrised operand-select / ripple-compare / event-count unit for the s1423 family.
//  - Each accepted sample picks an operand: live input din, or the captured hold register.
//  - The operand is compared unsigned against a programmable threshold.
//  - Qualifying compares are counted; a terminal-count pulse marks overflow.
//  - Sits between sample capture logic and downstream status/interrupt logic.

---
 rtl/s1423_pkg.sv | 11 +
 rtl/s1423_ge_ripple.sv | 21 ++
 rtl/s1423_cmp_count_unit.sv | 85 ++++++++
 3 files changed

// File: rtl/s1423_pkg.sv
// Shared constants and helpers for the s1423 compare/count unit.
package s1423_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  function automatic int unsigned cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/s1423_ge_ripple.sv
// Combinational unsigned a >= b, resolved LSB to MSB.
module s1423_ge_ripple #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ge
);

  logic [WIDTH:0] c;

  // Equal bits pass the lower result up; equal operands give 1.
  assign c[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign c[i+1] = (a[i] ^ b[i]) ? a[i] : c[i];
  end

  assign ge = c[WIDTH];

endmodule

// File: rtl/s1423_cmp_count_unit.sv
// Operand select, ripple compare and event counter with
// terminal-count pulse.
module s1423_cmp_count_unit
  import s1423_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int CNT_W = 4,
  parameter int MODE  = MODE_WRAP
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             in_valid,
  input  logic             sel,
  input  logic [WIDTH-1:0] din,
  input  logic             load_hold,
  input  logic [WIDTH-1:0] thr_in,
  input  logic             load_thr,
  input  logic             en,
  input  logic             clr,
  output logic             out_valid,
  output logic             ge,
  output logic [CNT_W-1:0] cnt,
  output logic             tc,
  output logic [WIDTH-1:0] hold_q
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));

  logic [WIDTH-1:0] thr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             ov_q, ge_q, ge_d;
  logic [WIDTH-1:0] operand;
  logic             ge_c, evt;

  assign operand = sel ? hold_q : din;

  s1423_ge_ripple #(.WIDTH(WIDTH)) u_ge (
    .a (operand),
    .b (thr_q),
    .ge(ge_c)
  );

  assign evt  = in_valid & en & ge_c & ~clr;
  assign ge_d = in_valid ? ge_c : ge_q;

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (evt) begin
      if (cnt_q == MAX) begin
        tc_d  = 1'b1;
        cnt_d = (MODE == MODE_SAT) ? MAX : '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      hold_q <= '0;
      thr_q  <= '0;
      cnt_q  <= '0;
      tc_q   <= 1'b0;
      ov_q   <= 1'b0;
      ge_q   <= 1'b0;
    end else begin
      if (load_hold) hold_q <= din;
      if (load_thr)  thr_q  <= thr_in;
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ov_q  <= in_valid;
      ge_q  <= ge_d;
    end
  end

  assign out_valid = ov_q;
  assign ge        = ge_q;
  assign cnt       = cnt_q;
  assign tc        = tc_q;

endmodule
